// File: rtl/wb_arbiter_pkg.sv
// Shared constants and helpers for the multi-channel GPR write-back arbiter.
package wb_arbiter_pkg;

    localparam int unsigned CH_ALU   = 0;
    localparam int unsigned CH_LSU   = 1;
    localparam int unsigned CH_MDU   = 2;
    localparam int unsigned ZERO_REG = 0;

    // Width of a channel index; never below one bit.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin grant logic with optional fixed-priority channel 0.
module wb_rr_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH   = 3,
    parameter bit          PRIO_CH0 = 1'b0,
    localparam int unsigned CH_W    = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt,
    output logic              gnt_vld,
    output logic [CH_W-1:0]   gnt_idx
);

    logic [CH_W-1:0] ptr_q;
    logic [CH_W-1:0] ptr_d;
    logic [CH_W-1:0] idx;
    logic            prio_hit;

    // Pick the first requester at or after the pointer, unless channel 0 has priority.
    always_comb begin
        gnt      = '0;
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        prio_hit = 1'b0;
        idx      = '0;
        ptr_d    = ptr_q;
        if (en) begin
            if (PRIO_CH0 && req[0]) begin
                gnt_vld  = 1'b1;
                prio_hit = 1'b1;
            end else begin
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    idx = CH_W'((32'(ptr_q) + k) % NUM_CH);
                    if (!gnt_vld && req[idx]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = idx;
                    end
                end
            end
        end
        if (gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
        end
        // A priority win must not disturb the fairness order of the others.
        if (gnt_vld && !prio_hit) begin
            ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Multi-channel write-back arbiter feeding one registered GPR write port with bypass.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned XLEN     = 64,
    parameter int unsigned RA_W     = 5,
    parameter bit          PRIO_CH0 = 1'b0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_valid,
    output logic [NUM_CH-1:0]        ch_ready,
    input  logic [NUM_CH*RA_W-1:0]   ch_rd,
    input  logic [NUM_CH-1:0]        ch_dest_wen,
    input  logic [NUM_CH*XLEN-1:0]   ch_data,
    input  logic                     wb_stall,
    input  logic                     flush,
    output logic                     rf_wen,
    output logic [RA_W-1:0]          rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    output logic [ch_idx_w(NUM_CH)-1:0] rf_wch,
    input  logic [RA_W-1:0]          rs1,
    input  logic [RA_W-1:0]          rs2,
    output logic                     byp_hit1,
    output logic                     byp_hit2,
    output logic [XLEN-1:0]          byp_data1,
    output logic [XLEN-1:0]          byp_data2,
    output logic [CNT_W-1:0]         conflict_cnt
);

    localparam int unsigned CH_W = ch_idx_w(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [RA_W-1:0]  RA_ZERO = RA_W'(ZERO_REG);

    logic              accept_en;
    logic [NUM_CH-1:0] gnt;
    logic              gnt_vld;
    logic [CH_W-1:0]   gnt_idx;
    logic [RA_W-1:0]   sel_rd;
    logic [XLEN-1:0]   sel_data;
    logic              sel_wen;
    logic              conflict;

    logic              rf_wen_q,   rf_wen_d;
    logic [RA_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic [CH_W-1:0]   rf_wch_q,   rf_wch_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    assign accept_en = ~(wb_stall | flush | rst);

    wb_rr_arbiter #(
        .NUM_CH   (NUM_CH),
        .PRIO_CH0 (PRIO_CH0)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (ch_valid),
        .en      (accept_en),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    assign ch_ready = gnt;

    // Payload of the granted channel; rd=x0 still takes the slot but never writes.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        sel_wen  = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (gnt_idx == CH_W'(i)) begin
                sel_rd   = ch_rd[i*RA_W +: RA_W];
                sel_data = ch_data[i*XLEN +: XLEN];
                sel_wen  = ch_dest_wen[i] && (ch_rd[i*RA_W +: RA_W] != RA_ZERO);
            end
        end
    end

    assign conflict = ($countones(ch_valid) > 1) && !flush;

    // Flush beats stall; a stalled stage holds everything.
    always_comb begin
        rf_wen_d   = rf_wen_q;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        rf_wch_d   = rf_wch_q;
        cnt_d      = cnt_q;
        if (flush) begin
            rf_wen_d = 1'b0;
        end else if (!wb_stall) begin
            rf_wen_d = gnt_vld & sel_wen;
            if (gnt_vld) begin
                rf_waddr_d = sel_rd;
                rf_wdata_d = sel_data;
                rf_wch_d   = gnt_idx;
            end
        end
        if (conflict && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            rf_wch_q   <= '0;
            cnt_q      <= '0;
        end else begin
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_wch_q   <= rf_wch_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rf_wen       = rf_wen_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign rf_wch       = rf_wch_q;
    assign conflict_cnt = cnt_q;

    assign byp_hit1  = rf_wen_q && (rs1 == rf_waddr_q) && (rs1 != RA_ZERO);
    assign byp_hit2  = rf_wen_q && (rs2 == rf_waddr_q) && (rs2 != RA_ZERO);
    assign byp_data1 = byp_hit1 ? rf_wdata_q : '0;
    assign byp_data2 = byp_hit2 ? rf_wdata_q : '0;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: plain round-robin and priority/narrow-counter builds in parallel.
module tb_wb_arbiter;

    typedef struct packed {
        logic        wen;
        logic [4:0]  waddr;
        logic [63:0] wdata;
        logic [1:0]  wch;
        logic [15:0] cnt;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [2:0]   ch_valid;
    logic [14:0]  ch_rd;
    logic [2:0]   ch_dest_wen;
    logic [191:0] ch_data;
    logic         wb_stall;
    logic         flush;
    logic [4:0]   rs1;
    logic [4:0]   rs2;

    logic [2:0]  rr_ready, pr_ready;
    logic        rr_wen, pr_wen;
    logic [4:0]  rr_waddr, pr_waddr;
    logic [63:0] rr_wdata, pr_wdata;
    logic [1:0]  rr_wch, pr_wch;
    logic        rr_h1, rr_h2, pr_h1, pr_h2;
    logic [63:0] rr_d1, rr_d2, pr_d1, pr_d2;
    logic [15:0] rr_cnt;
    logic [1:0]  pr_cnt;

    wb_arbiter #(.NUM_CH(3), .XLEN(64), .RA_W(5), .PRIO_CH0(1'b0), .CNT_W(16)) u_rr (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_ready(rr_ready), .ch_rd(ch_rd),
        .ch_dest_wen(ch_dest_wen), .ch_data(ch_data), .wb_stall(wb_stall), .flush(flush),
        .rf_wen(rr_wen), .rf_waddr(rr_waddr), .rf_wdata(rr_wdata), .rf_wch(rr_wch),
        .rs1(rs1), .rs2(rs2), .byp_hit1(rr_h1), .byp_hit2(rr_h2),
        .byp_data1(rr_d1), .byp_data2(rr_d2), .conflict_cnt(rr_cnt)
    );

    wb_arbiter #(.NUM_CH(3), .XLEN(64), .RA_W(5), .PRIO_CH0(1'b1), .CNT_W(2)) u_pr (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_ready(pr_ready), .ch_rd(ch_rd),
        .ch_dest_wen(ch_dest_wen), .ch_data(ch_data), .wb_stall(wb_stall), .flush(flush),
        .rf_wen(pr_wen), .rf_waddr(pr_waddr), .rf_wdata(pr_wdata), .rf_wch(pr_wch),
        .rs1(rs1), .rs2(rs2), .byp_hit1(pr_h1), .byp_hit2(pr_h2),
        .byp_data1(pr_d1), .byp_data2(pr_d2), .conflict_cnt(pr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, index 0 = round-robin build, 1 = priority build.
    int          m_ptr[2];
    logic        m_wen[2];
    logic [4:0]  m_waddr[2];
    logic [63:0] m_wdata[2];
    int          m_wch[2];
    int          m_cnt[2];
    int          cmax[2] = '{65535, 3};
    bit          prio[2] = '{1'b0, 1'b1};
    exp_t        sb_q[2][$];
    logic [2:0]  obs_rdy_rr, obs_rdy_pr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int i, input bit v, input bit w, input logic [4:0] rd,
                          input logic [63:0] d);
        ch_valid[i]        = v;
        ch_dest_wen[i]     = w;
        ch_rd[i*5 +: 5]    = rd;
        ch_data[i*64 +: 64] = d;
    endtask

    function automatic int pick(input int n);
        int idx;
        if (rst || wb_stall || flush) return -1;
        if (prio[n] && ch_valid[0]) return 0;
        for (int k = 0; k < 3; k++) begin
            idx = (m_ptr[n] + k) % 3;
            if (ch_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_step(input int n, input int g);
        logic [4:0] rd;
        exp_t e;
        if (rst) begin
            m_ptr[n] = 0; m_wen[n] = 1'b0; m_waddr[n] = '0;
            m_wdata[n] = '0; m_wch[n] = 0; m_cnt[n] = 0;
        end else begin
            if ($countones(ch_valid) >= 2 && !flush && m_cnt[n] < cmax[n]) m_cnt[n]++;
            if (flush) begin
                m_wen[n] = 1'b0;
            end else if (!wb_stall) begin
                if (g >= 0) begin
                    rd = ch_rd[g*5 +: 5];
                    m_wen[n]   = ch_dest_wen[g] && (rd != 5'd0);
                    m_waddr[n] = rd;
                    m_wdata[n] = ch_data[g*64 +: 64];
                    m_wch[n]   = g;
                    if (!(prio[n] && g == 0)) m_ptr[n] = (g + 1) % 3;
                end else begin
                    m_wen[n] = 1'b0;
                end
            end
        end
        e.wen = m_wen[n]; e.waddr = m_waddr[n]; e.wdata = m_wdata[n];
        e.wch = 2'(m_wch[n]); e.cnt = 16'(m_cnt[n]);
        sb_q[n].push_back(e);
    endtask

    task automatic cmp_inst(input int n, input string p, input logic wen, input logic [4:0] waddr,
                            input logic [63:0] wdata, input logic [1:0] wch, input logic [15:0] cnt,
                            input logic h1, input logic h2, input logic [63:0] d1,
                            input logic [63:0] d2);
        exp_t e;
        logic eh1, eh2;
        if (sb_q[n].size() == 0) begin
            chk({p, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb_q[n].pop_front();
        chk({p, "_wen"}, 64'(wen), 64'(e.wen));
        chk({p, "_waddr"}, 64'(waddr), 64'(e.waddr));
        chk({p, "_wdata"}, wdata, e.wdata);
        chk({p, "_wch"}, 64'(wch), 64'(e.wch));
        chk({p, "_cnt"}, 64'(cnt), 64'(e.cnt));
        eh1 = e.wen && (rs1 == e.waddr) && (rs1 != 5'd0);
        eh2 = e.wen && (rs2 == e.waddr) && (rs2 != 5'd0);
        chk({p, "_hit1"}, 64'(h1), 64'(eh1));
        chk({p, "_hit2"}, 64'(h2), 64'(eh2));
        chk({p, "_bdata1"}, d1, eh1 ? e.wdata : 64'd0);
        chk({p, "_bdata2"}, d2, eh2 ? e.wdata : 64'd0);
    endtask

    // One clock: check ready mid-cycle, advance the model, check registered outputs after the edge.
    task automatic cycle();
        int g0, g1;
        logic [2:0] e0, e1;
        @(negedge clk);
        g0 = pick(0);
        g1 = pick(1);
        e0 = '0; e1 = '0;
        if (g0 >= 0) e0[g0] = 1'b1;
        if (g1 >= 0) e1[g1] = 1'b1;
        obs_rdy_rr = rr_ready;
        obs_rdy_pr = pr_ready;
        chk("rr_ready", 64'(rr_ready), 64'(e0));
        chk("pr_ready", 64'(pr_ready), 64'(e1));
        model_step(0, g0);
        model_step(1, g1);
        @(posedge clk);
        #1;
        cmp_inst(0, "rr", rr_wen, rr_waddr, rr_wdata, rr_wch, rr_cnt, rr_h1, rr_h2, rr_d1, rr_d2);
        cmp_inst(1, "pr", pr_wen, pr_waddr, pr_wdata, pr_wch, 16'(pr_cnt), pr_h1, pr_h2, pr_d1, pr_d2);
    endtask

    task automatic clear_ch();
        for (int i = 0; i < 3; i++) set_ch(i, 1'b0, 1'b0, 5'd0, 64'd0);
    endtask

    task automatic reset_pulse();
        clear_ch();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    int order[6]     = '{0, 1, 2, 0, 1, 2};
    int sat_cnt[4]   = '{1, 2, 3, 3};
    int saved_cnt;

    initial begin
        rst = 1'b1; wb_stall = 1'b0; flush = 1'b0; rs1 = '0; rs2 = '0;
        ch_valid = '0; ch_rd = '0; ch_dest_wen = '0; ch_data = '0;
        for (int n = 0; n < 2; n++) begin
            m_ptr[n] = 0; m_wen[n] = 1'b0; m_waddr[n] = '0; m_wdata[n] = '0;
            m_wch[n] = 0; m_cnt[n] = 0;
        end

        cycle();
        cycle();
        chk("rst_wen", 64'(rr_wen), 64'd0);
        chk("rst_wdata", rr_wdata, 64'd0);
        chk("rst_cnt", 64'(rr_cnt), 64'd0);
        rst = 1'b0;

        // All three producers busy: strict rotation, one write per grant.
        for (int i = 0; i < 3; i++) set_ch(i, 1'b1, 1'b1, 5'(i + 1), 64'(10 + i));
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("rot_wch", 64'(rr_wch), 64'(order[k]));
            chk("rot_wdata", rr_wdata, 64'(10 + order[k]));
            chk("rot_wen", 64'(rr_wen), 64'd1);
            chk("prio_wch", 64'(pr_wch), 64'd0);
        end
        chk("rot_cnt", 64'(rr_cnt), 64'd6);
        chk("sat_cnt_pr", 64'(pr_cnt), 64'd3);

        // Channel 0 priority against channel 2.
        reset_pulse();
        set_ch(0, 1'b1, 1'b1, 5'd1, 64'hA);
        set_ch(2, 1'b1, 1'b1, 5'd3, 64'hC);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("prio_rdy2", 64'(obs_rdy_pr[2]), 64'd0);
            chk("prio_win", 64'(pr_wch), 64'd0);
        end

        // rd=x0 is accepted but never writes or bypasses.
        clear_ch();
        set_ch(0, 1'b1, 1'b1, 5'd0, 64'hDEAD);
        rs1 = 5'd0;
        cycle();
        chk("x0_rdy", 64'(obs_rdy_rr), 64'b001);
        chk("x0_wen", 64'(rr_wen), 64'd0);
        chk("x0_wdata", rr_wdata, 64'hDEAD);
        chk("x0_hit1", 64'(rr_h1), 64'd0);

        // Stall holds the pending write, bypass still sees it.
        set_ch(0, 1'b1, 1'b1, 5'd5, 64'h1234);
        cycle();
        set_ch(0, 1'b0, 1'b0, 5'd0, 64'd0);
        set_ch(1, 1'b1, 1'b1, 5'd9, 64'h99);
        wb_stall = 1'b1;
        rs2 = 5'd5;
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk("stall_rdy", 64'(obs_rdy_rr), 64'd0);
            chk("stall_waddr", 64'(rr_waddr), 64'd5);
            chk("stall_wdata", rr_wdata, 64'h1234);
            chk("stall_hit2", 64'(rr_h2), 64'd1);
            chk("stall_bdata2", rr_d2, 64'h1234);
        end
        wb_stall = 1'b0;
        cycle();

        // Flush: write already on rf completes, nothing new accepted, counter frozen.
        clear_ch();
        set_ch(0, 1'b1, 1'b1, 5'd7, 64'h77);
        cycle();
        set_ch(1, 1'b1, 1'b1, 5'd8, 64'h88);
        flush = 1'b1;
        chk("flush_pre_wen", 64'(rr_wen), 64'd1);
        chk("flush_pre_waddr", 64'(rr_waddr), 64'd7);
        saved_cnt = m_cnt[0];
        cycle();
        chk("flush_rdy", 64'(obs_rdy_rr), 64'd0);
        chk("flush_wen", 64'(rr_wen), 64'd0);
        chk("flush_cnt", 64'(rr_cnt), 64'(saved_cnt));
        flush = 1'b0;
        clear_ch();
        set_ch(0, 1'b1, 1'b1, 5'd7, 64'h77);
        cycle();
        flush = 1'b1;
        wb_stall = 1'b1;
        cycle();
        chk("flush_stall_wen", 64'(rr_wen), 64'd0);
        flush = 1'b0;
        wb_stall = 1'b0;

        // Narrow counter saturates, then reset lands mid-stream.
        reset_pulse();
        set_ch(0, 1'b1, 1'b1, 5'd2, 64'h2);
        set_ch(1, 1'b1, 1'b1, 5'd4, 64'h4);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("sat_cnt", 64'(pr_cnt), 64'(sat_cnt[k]));
        end
        rst = 1'b1;
        cycle();
        chk("midrst_rdy", 64'(obs_rdy_rr), 64'd0);
        chk("midrst_wen", 64'(rr_wen), 64'd0);
        chk("midrst_waddr", 64'(pr_waddr), 64'd0);
        chk("midrst_cnt", 64'(pr_cnt), 64'd0);
        rst = 1'b0;

        // Random traffic against the model.
        for (int k = 0; k < 200; k++) begin
            for (int i = 0; i < 3; i++)
                set_ch(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                       5'($urandom_range(0, 3)), {$urandom, $urandom});
            wb_stall = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            rst      = ($urandom_range(0, 31) == 0);
            rs1      = 5'($urandom_range(0, 3));
            rs2      = 5'($urandom_range(0, 3));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Multi-channel write-back arbiter that generalises the single-source GPR write path of the write-back unit.
- Up to NUM_CH producers (ALU, LSU, MUL/DIV, CSR read) compete for one registered GPR write port.
- Arbitration is round-robin, with an optional fixed-priority channel 0, stall back-pressure, flush, an rs1/rs2 bypass of the pending write, and a saturating conflict counter.
- Sits between the execute/LSU pipeline registers and gpr.

Parameters:
NUM_CH, 3, number of write-back channels (2..8)
XLEN, 64, data width
RA_W, 5, register address width
PRIO_CH0, 0, 1 = channel 0 always wins when valid; 0 = channel 0 takes part in plain round-robin
CNT_W, 16, width of the conflict counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ch_valid  in  NUM_CH  per-channel write-back request
ch_ready  out  NUM_CH  per-channel accept (combinational, one-hot or zero)
ch_rd  in  NUM_CH*RA_W  destination register, channel i at [i*RA_W +: RA_W]
ch_dest_wen  in  NUM_CH  channel writes a GPR
ch_data  in  NUM_CH*XLEN  write data, channel i at [i*XLEN +: XLEN]
wb_stall  in  1  downstream cannot take a new write this cycle
flush  in  1  pipeline flush (trap, jump, satp change)
rf_wen  out  1  registered GPR write enable
rf_waddr  out  RA_W  registered write address
rf_wdata  out  XLEN  registered write data
rf_wch  out  $clog2(NUM_CH)  channel that produced the current write
rs1  in  RA_W  bypass lookup address 1
rs2  in  RA_W  bypass lookup address 2
byp_hit1  out  1  rs1 matches the pending write
byp_hit2  out  1  rs2 matches the pending write
byp_data1  out  XLEN  bypass data for rs1
byp_data2  out  XLEN  bypass data for rs2
conflict_cnt  out  CNT_W  cycles in which more than one channel requested

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: rf_wen=0, rf_waddr=0, rf_wdata=0, rf_wch=0, round-robin pointer=0, conflict_cnt=0.
- Handshake: a transfer occurs on ch_valid[i] & ch_ready[i].
  - Producers hold valid and payload stable until accepted.
  - ch_ready is 0 for every channel while wb_stall=1, flush=1 or rst=1.
- Grant selection:
  - PRIO_CH0=1 and ch_valid[0]=1: channel 0 is granted.
  - Otherwise: the first valid channel at or after the pointer, searching upward with wrap from NUM_CH-1 to 0.
  - Exactly one channel is granted per cycle; ch_ready is one-hot or zero.
- Pointer update: after a round-robin grant to channel i, the pointer becomes (i+1) mod NUM_CH. A priority grant to channel 0 leaves the pointer unchanged. No grant leaves the pointer unchanged.
- Output register:
  - Latency is 1 cycle: the grant in cycle N gives rf_wen/rf_waddr/rf_wdata/rf_wch in cycle N+1.
  - rf_wen = ch_dest_wen[i] & (ch_rd[i] != 0).
  - An rd=0 request, or one with ch_dest_wen=0, is still accepted and consumes the slot, but produces rf_wen=0.
  - rf_wch is loaded with the granted channel index.
  - rf_wdata and rf_waddr load the granted payload even when rf_wen=0.
- Stall: while wb_stall=1 all rf_* outputs hold their values. wb_stall has no effect on the conflict counter.
- Flush: no channel is accepted in the flush cycle, and rf_wen=0 in the next cycle. A write already present on rf_* in the flush cycle is not cancelled and reaches the GPR.
- flush together with wb_stall: flush wins; rf_wen clears next cycle.
- Bypass (combinational from the registered stage):
  - byp_hitK = rf_wen & (rsK == rf_waddr) & (rsK != 0).
  - byp_dataK = rf_wdata when byp_hitK=1, else 0.
- Conflict counter: increments by 1 in every cycle where popcount(ch_valid) >= 2 and flush=0. It saturates at all-ones and never wraps.
- Reset mid-operation: all state returns to reset values on the next edge. No partially accepted request survives.

Decomposition:
- Shared package/define file: channel index width function, channel ID constants (CH_ALU=0, CH_LSU=1, CH_MDU=2), and the ZERO_REG constant.
- One natural sub-module, wb_rr_arbiter, holds only the grant logic: NUM_CH request vector, pointer register, PRIO_CH0 override, one-hot grant output.
- Payload muxing, the output register, bypass and the counter stay in wb_arbiter.

Test Plan:
- NUM_CH=3, PRIO_CH0=0, all three valid for 6 cycles with rd=1/2/3 and data=0xA/0xB/0xC -> grant order 0,1,2,0,1,2. Each rf write appears one cycle after its grant. conflict_cnt=6 (the 6th cycle has all three still valid).
- PRIO_CH0=1, channels 0 and 2 valid continuously for 3 cycles -> channel 0 wins every cycle, the pointer stays at 0, and ch_ready[2]=0 throughout.
- Single request with rd=0, wen=1, data=0xDEAD -> ch_ready=1, next-cycle rf_wen=0; rs1=0 gives byp_hit1=0.
- Grant to rd=5, data=0x1234, then wb_stall=1 for 2 cycles with ch1 valid -> rf_* hold rd=5/0x1234, ch_ready=0. With rs2=5: byp_hit2=1, byp_data2=0x1234.
- flush=1 while ch0/ch1 valid and rf holds rd=7 -> the rd=7 write stays on rf_* in the flush cycle; next cycle rf_wen=0, nothing accepted, conflict_cnt unchanged.
- CNT_W=2, four conflict cycles -> counter reads 1,2,3,3 (saturates). Assert rst mid-stream -> all outputs zero at the next edge.
